// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding and ASCII constants for the UART printers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CONV_H  = 4'd1,
        ST_CONV_T  = 4'd2,
        ST_EMIT_H  = 4'd3,
        ST_EMIT_T  = 4'd4,
        ST_EMIT_O  = 4'd5,
        ST_EMIT_CR = 4'd6,
        ST_EMIT_LF = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

`default_nettype wire

// File: rtl/uart_num2ascii.sv
// ============================================================================
// Module   : uart_num2ascii
// Brief    : Maps a decimal digit 0-9 to its ASCII character, '?' otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_num2ascii
    import uart_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        if (digit <= 4'd9) begin
            ascii = ASCII_ZERO + {4'd0, digit};
        end else begin
            ascii = ASCII_QMARK;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_dec_printer.sv
// ============================================================================
// Module   : uart_dec_printer
// Brief    : Prints an 8-bit unsigned value as decimal text into a TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_dec_printer
    import uart_pkg::*;
#(
    parameter bit LEAD_ZERO = 1'b0,
    parameter bit NEWLINE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    input  logic       tx_ready,
    output logic       tx_write,
    output logic [7:0] tx_data
);

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] w_digit;
    logic [7:0] w_ascii;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hcnt_d  = hcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = value;
                    hcnt_d  = 8'd0;
                    tcnt_d  = 8'd0;
                    state_d = ST_CONV_H;
                end
            end
            ST_CONV_H: begin
                if (rem_q >= 8'd100) begin
                    rem_d  = rem_q - 8'd100;
                    hcnt_d = hcnt_q + 8'd1;
                end else begin
                    state_d = ST_CONV_T;
                end
            end
            ST_CONV_T: begin
                if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tcnt_d = tcnt_q + 8'd1;
                end else if (LEAD_ZERO || (hcnt_q != 8'd0)) begin
                    state_d = ST_EMIT_H;
                end else if (tcnt_q != 8'd0) begin
                    state_d = ST_EMIT_T;
                end else begin
                    state_d = ST_EMIT_O;
                end
            end
            // Once the hundreds digit is printed the tens digit always follows, even when zero.
            ST_EMIT_H:  if (tx_ready) state_d = ST_EMIT_T;
            ST_EMIT_T:  if (tx_ready) state_d = ST_EMIT_O;
            ST_EMIT_O:  if (tx_ready) state_d = NEWLINE ? ST_EMIT_CR : ST_DONE;
            ST_EMIT_CR: if (tx_ready) state_d = ST_EMIT_LF;
            ST_EMIT_LF: if (tx_ready) state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 8'd0;
            hcnt_q  <= 8'd0;
            tcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hcnt_q  <= hcnt_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        w_digit = rem_q[3:0];
        case (state_q)
            ST_EMIT_H: w_digit = hcnt_q[3:0];
            ST_EMIT_T: w_digit = tcnt_q[3:0];
            default:   w_digit = rem_q[3:0];
        endcase
    end

    uart_num2ascii u_num2ascii (
        .digit (w_digit),
        .ascii (w_ascii)
    );

    always_comb begin
        tx_write = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_EMIT_H, ST_EMIT_T, ST_EMIT_O: begin
                tx_data  = w_ascii;
                tx_write = tx_ready;
            end
            ST_EMIT_CR: begin
                tx_data  = ASCII_CR;
                tx_write = tx_ready;
            end
            ST_EMIT_LF: begin
                tx_data  = ASCII_LF;
                tx_write = tx_ready;
            end
            default: begin
                tx_write = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_dec_printer.sv
// ============================================================================
// Module   : tb_uart_dec_printer
// Brief    : Scoreboard bench for two printer variants (default and 3-digit/no-newline).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_dec_printer;

    typedef logic [7:0] bq_t[$];

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      start;
    logic [7:0]      value0, value1;
    logic [1:0]      busy, done, wr, rdy;
    logic [1:0][7:0] data;
    int              rmode [2];

    int total = 0;
    int bad   = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always #5 clk = ~clk;

    uart_dec_printer #(.LEAD_ZERO(1'b0), .NEWLINE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .value(value0),
        .busy(busy[0]), .done(done[0]), .tx_ready(rdy[0]),
        .tx_write(wr[0]), .tx_data(data[0])
    );

    uart_dec_printer #(.LEAD_ZERO(1'b1), .NEWLINE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .value(value1),
        .busy(busy[1]), .done(done[1]), .tx_ready(rdy[1]),
        .tx_write(wr[1]), .tx_data(data[1])
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Decimal text from plain arithmetic on the value.
    function automatic bq_t model(input logic [7:0] v, input bit lz, input bit nl);
        bq_t q;
        int h = int'(v) / 100;
        int t = (int'(v) / 10) % 10;
        int o = int'(v) % 10;
        if (lz || h != 0) q.push_back(8'(8'h30 + h));
        if (lz || h != 0 || t != 0) q.push_back(8'(8'h30 + t));
        q.push_back(8'(8'h30 + o));
        if (nl) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    initial begin
        rdy = 2'b11;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                case (rmode[d])
                    0:       rdy[d] = 1'b1;
                    1:       rdy[d] = ~rdy[d];
                    default: rdy[d] = 1'(($urandom % 2));
                endcase
            end
        end
    end

    logic [1:0]      pbusy, pdone, prdy;
    logic [1:0][7:0] pdata;
    always @(negedge clk) begin
        if (!rst_n) begin
            pbusy = 2'b00;
            pdone = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wr[d]) begin
                    logic [7:0] e;
                    int sz;
                    check("write_needs_ready", int'(rdy[d]), 1);
                    check("no_qmark_byte", int'(data[d] == 8'h3F), 0);
                    sz = (d == 0) ? exp0.size() : exp1.size();
                    if (sz == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write dut%0d actual=0x%0h required=none", d, data[d]);
                    end else begin
                        if (d == 0) e = exp0.pop_front();
                        else        e = exp1.pop_front();
                        check($sformatf("byte_dut%0d", d), int'(data[d]), int'(e));
                    end
                end
                if (pdone[d]) check("busy_low_after_done", int'(busy[d]), 0);
                if (done[d])  check("busy_high_with_done", int'(busy[d]), 1);
                if (pbusy[d] && !prdy[d] && pdata[d] != 8'h00)
                    check("data_stable_in_stall", int'(data[d]), int'(pdata[d]));
                pbusy[d] = busy[d];
                pdone[d] = done[d];
                prdy[d]  = rdy[d];
                pdata[d] = data[d];
            end
        end
    end

    task automatic run_print(input int d, input logic [7:0] v, input int mode, input bit repulse);
        bq_t q = model(v, d == 1, d == 0);
        int  n = 0;
        bit  got_w = 1'b0;
        int  h = int'(v) / 100;
        int  t = (int'(v) / 10) % 10;
        foreach (q[i]) begin
            if (d == 0) exp0.push_back(q[i]);
            else        exp1.push_back(q[i]);
        end
        rmode[d] = mode;
        @(posedge clk);
        #2;
        start[d] = 1'b1;
        if (d == 0) value0 = v; else value1 = v;
        @(posedge clk);
        #2;
        start[d] = 1'b0;
        if (d == 0) value0 = 8'($urandom); else value1 = 8'($urandom);
        while (!done[d] && n < 300) begin
            @(negedge clk);
            n++;
            if (wr[d] && !got_w) begin
                got_w = 1'b1;
                if (mode == 0) check("first_write_latency", n, h + t + 3);
            end
            if (repulse && n == 4) begin
                start[d] = 1'b1;
                if (d == 0) value0 = 8'd42; else value1 = 8'd42;
            end
            if (repulse && n == 7) start[d] = 1'b0;
        end
        start[d] = 1'b0;
        check("done_seen", int'(done[d]), 1);
        check("bytes_left", (d == 0) ? exp0.size() : exp1.size(), 0);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 2'b00;
        value0 = 8'd0;
        value1 = 8'd0;
        rmode[0] = 0;
        rmode[1] = 0;
        #23;
        for (int d = 0; d < 2; d++) begin
            check("reset_busy",  int'(busy[d]), 0);
            check("reset_done",  int'(done[d]), 0);
            check("reset_write", int'(wr[d]),   0);
            check("reset_data",  int'(data[d]), 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_print(0, 8'd0,   0, 1'b0);
        run_print(0, 8'd255, 0, 1'b0);
        run_print(1, 8'd7,   0, 1'b0);
        run_print(0, 8'd105, 1, 1'b0);
        run_print(0, 8'd123, 0, 1'b1);

        // Abandon a print of 250 after its first byte with an asynchronous reset.
        exp0.push_back(8'h32);
        rmode[0] = 0;
        @(posedge clk);
        #2;
        start[0] = 1'b1;
        value0   = 8'd250;
        @(posedge clk);
        #2;
        start[0] = 1'b0;
        n = 0;
        while (!wr[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_byte_before_reset", int'(wr[0]), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",  int'(busy[0]), 0);
        check("async_rst_write", int'(wr[0]),   0);
        check("async_rst_data",  int'(data[0]), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_print(0, 8'd9, 0, 1'b0);

        run_print(1, 8'd0,   0, 1'b0);
        run_print(1, 8'd255, 1, 1'b0);
        run_print(1, 8'd90,  2, 1'b0);
        for (int i = 0; i < 30; i++) begin
            run_print(int'($urandom % 2), 8'($urandom), int'($urandom % 3), 1'($urandom % 2));
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
